// File: rtl/alu_simple.sv
// alu_simple: 32-bit single-cycle ALU with a barrel pre-shifter on the
// second operand, used in the CPU execute stage.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst_n    - synchronous active-low reset (clears Out)
//   In1      - operand A, used unshifted
//   In2      - operand B, passed through the shifter before the ALU op
//   opcode   - operation select (ADD/SUB/MUL/OR/AND/XOR; others give 0)
//   SR_Bit   - shift/rotate amount, 0..31
//   SR_Cont  - shifter mode select
//   Out      - registered result, valid one cycle after the inputs
module alu_simple #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       opcode,
  input  logic [4:0]       SR_Bit,
  input  logic [2:0]       SR_Cont,
  output logic [WIDTH-1:0] Out
);

  typedef enum logic [2:0] {
    SH_PASS = 3'b000,
    SH_LSR  = 3'b001,
    SH_LSL  = 3'b010,
    SH_ROR  = 3'b011,
    SH_ASR  = 3'b100,
    SH_ROL  = 3'b101
  } shift_mode_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_OR  = 4'b0011,
    OP_AND = 4'b0100,
    OP_XOR = 4'b0101
  } alu_op_e;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result;
  logic [5:0]       rot_comp;

  // Complementary amount for rotates. With SR_Bit = 0 this equals WIDTH,
  // and a shift by the full width yields zero, so the OR term vanishes
  // and the rotate degenerates cleanly to pass-through.
  assign rot_comp = 6'(WIDTH) - {1'b0, SR_Bit};

  always_comb begin
    shifted = In2;
    case (SR_Cont)
      SH_LSR:  shifted = In2 >> SR_Bit;
      SH_LSL:  shifted = In2 << SR_Bit;
      SH_ROR:  shifted = (In2 >> SR_Bit) | (In2 << rot_comp);
      SH_ASR:  shifted = $signed(In2) >>> SR_Bit;
      SH_ROL:  shifted = (In2 << SR_Bit) | (In2 >> rot_comp);
      default: shifted = In2;
    endcase
  end

  // Results are truncated to WIDTH; carry, borrow and overflow are dropped.
  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = In1 + shifted;
      OP_SUB:  result = In1 - shifted;
      OP_MUL:  result = In1 * shifted;
      OP_OR:   result = In1 | shifted;
      OP_AND:  result = In1 & shifted;
      OP_XOR:  result = In1 ^ shifted;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Out <= '0;
    end else begin
      Out <= result;
    end
  end

endmodule

// File: tb/tb_alu_simple.sv
// Self-checking bench for alu_simple: a bit-level behavioural model checked
// every cycle against Out, plus directed cases with literal expectations.
module tb_alu_simple;

  logic        clk;
  logic        rst_n;
  logic [31:0] In1;
  logic [31:0] In2;
  logic [3:0]  opcode;
  logic [4:0]  SR_Bit;
  logic [2:0]  SR_Cont;
  logic [31:0] Out;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [31:0] exp_out;

  alu_simple #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .In1(In1), .In2(In2), .opcode(opcode),
    .SR_Bit(SR_Bit), .SR_Cont(SR_Cont), .Out(Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter model: build each output bit from its source bit position.
  function automatic logic [31:0] model_shift(input logic [31:0] x,
                                              input logic [2:0] mode,
                                              input int n);
    logic [31:0] s;
    for (int i = 0; i < 32; i++) begin
      case (mode)
        3'd1:    s[i] = (i + n < 32) ? x[i + n] : 1'b0;
        3'd2:    s[i] = (i >= n) ? x[i - n] : 1'b0;
        3'd3:    s[i] = x[(i + n) % 32];
        3'd4:    s[i] = (i + n < 32) ? x[i + n] : x[31];
        3'd5:    s[i] = x[(i - n + 32) % 32];
        default: s[i] = x[i];
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [3:0] op,
                                        input logic [2:0] mode,
                                        input logic [4:0] n);
    longint unsigned sa, sb, r;
    sa = longint'(a);
    sb = longint'(model_shift(b, mode, int'(n)));
    case (op)
      4'd0:    r = (sa + sb) % 64'h1_0000_0000;
      4'd1:    r = (sa + 64'h1_0000_0000 - sb) % 64'h1_0000_0000;
      4'd2:    r = (sa * sb) % 64'h1_0000_0000;
      4'd3:    r = sa | sb;
      4'd4:    r = sa & sb;
      4'd5:    r = sa ^ sb;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // Continuous compare: expectation from inputs sampled at the edge,
  // checked just after it.
  always @(posedge clk) begin
    exp_out = rst_n ? model(In1, In2, opcode, SR_Cont, SR_Bit) : 32'h0;
    cycle++;
    #1;
    checks++;
    if (Out !== exp_out) begin
      errors++;
      $display("FAIL model_cmp cycle %0d: Out=%h expected=%h", cycle, Out, exp_out);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [2:0] mode,
                       input logic [4:0] n);
    @(negedge clk);
    In1 = a; In2 = b; opcode = op; SR_Cont = mode; SR_Bit = n;
  endtask

  task automatic directed(input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [2:0] mode, input logic [4:0] n,
                          input logic [31:0] lit);
    logic [31:0] m;
    drive(a, b, op, mode, n);
    m = model(a, b, op, mode, n);
    @(posedge clk);
    #1;
    checks++;
    if (Out !== lit) begin
      errors++;
      $display("FAIL %s: Out=%h expected=%h", name, Out, lit);
    end
    checks++;
    if (m !== lit) begin
      errors++;
      $display("FAIL %s_model: model=%h expected=%h", name, m, lit);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    In1 = 32'h1234_5678; In2 = 32'h0BAD_F00D; opcode = 4'd0;
    SR_Cont = 3'd0; SR_Bit = 5'd3;

    // Reset with nonzero inputs for two edges
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Out !== 32'h0) begin
      errors++;
      $display("FAIL reset: Out=%h expected=%h", Out, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    directed("add_15_20", 32'd15, 32'd20, 4'd0, 3'd0, 5'd0, 32'd35);
    directed("sub_30_10", 32'd30, 32'd10, 4'd1, 3'd0, 5'd0, 32'd20);
    directed("mul_5_5",   32'd5,  32'd5,  4'd2, 3'd0, 5'd0, 32'd25);
    directed("sub_wrap",  32'd0,  32'd1,  4'd1, 3'd0, 5'd0, 32'hFFFF_FFFF);
    directed("add_wrap",  32'hFFFF_FFFF, 32'd1, 4'd0, 3'd0, 5'd0, 32'h0);
    directed("or",        32'h0A0, 32'h005, 4'd3, 3'd0, 5'd0, 32'h0A5);
    directed("and",       32'h0F0, 32'h00F, 4'd4, 3'd0, 5'd0, 32'h000);
    directed("xor",       32'h0FF, 32'h0F0, 4'd5, 3'd0, 5'd0, 32'h00F);
    directed("reserved",  32'h0FF, 32'h0F0, 4'd6, 3'd0, 5'd0, 32'h0);
    directed("add_lsr4",  32'd30, 32'd10, 4'd0, 3'd1, 5'd4, 32'd30);
    directed("add_lsl4",  32'd30, 32'd10, 4'd0, 3'd2, 5'd4, 32'd190);
    directed("add_ror4",  32'd30, 32'd10, 4'd0, 3'd3, 5'd4, 32'hA000_001E);
    directed("add_rol4",  32'd30, 32'd10, 4'd0, 3'd5, 5'd4, 32'd190);
    directed("asr4",      32'd0, 32'h8000_0000, 4'd0, 3'd4, 5'd4, 32'hF800_0000);
    directed("lsr4_neg",  32'd0, 32'h8000_0000, 4'd0, 3'd1, 5'd4, 32'h0800_0000);
    directed("ror31",     32'd0, 32'h0000_0001, 4'd0, 3'd3, 5'd31, 32'h0000_0002);
    for (int m = 0; m < 8; m++)
      directed("shamt0", 32'd0, 32'h8123_4567, 4'd0, 3'(m), 5'd0, 32'h8123_4567);

    // Back-to-back with a one-edge reset in the middle
    for (int i = 0; i < 8; i++) begin
      drive($urandom, $urandom, 4'($urandom_range(0, 6)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      rst_n = (i != 4);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Random soak with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive($urandom, $urandom, 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      rst_n = ($urandom_range(0, 19) != 0);
    end
    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
